// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: deserialises DATA_WIDTH bits MSB-first from mosi
// and shifts a preloaded reply word out on miso in the same frame.
module spi_slave_rx #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [1:0]            warm_q, warm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;
  logic                  tx_ready_q, tx_ready_d;

  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                  mosi_s2, cs_s2;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  word_done;

  assign sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
  assign cs_sync_d   = {cs_sync_q[1:0], cs};
  assign mosi_sync_d = {mosi_sync_q[0], mosi};

  assign mosi_s2   = mosi_sync_q[1];
  assign cs_s2     = cs_sync_q[1];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2};

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      // The cs chain powers up reading 1, so wait until it holds real samples
      // before trusting a high level; otherwise a cs held low through reset
      // release would look like a fresh frame.
      SYNC: begin
        if (warm_q != 2'd3) begin
          warm_d = warm_q + 2'd1;
        end else if (cs_s2) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (tx_load) begin
          tx_buf_d = tx_data;
        end
        if (cs_fall) begin
          tx_shift_d = tx_load ? tx_data : tx_buf_q;
          tx_buf_d   = '0;
          cnt_d      = '0;
          rx_shift_d = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = rx_word;
          cnt_d      = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            word_done  = 1'b1;
            state_d    = DONE;
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
        // A rise in the same cycle counts first, so a completed word wins.
        if (cs_rise) begin
          state_d    = IDLE;
          rx_shift_d = '0;
          if (!word_done && cnt_d != '0) begin
            frame_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase

    tx_ready_d = (state_d == IDLE);
    miso_d     = ((state_d == ACTIVE) || (state_d == DONE)) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SYNC;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      warm_q      <= 2'd0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      warm_q      <= warm_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed frame table, randomised frames
// against a word-level reference model, and a mid-frame reset sequence.
module tb_spi_slave_rx;
  localparam int W    = 6;
  localparam int HALF = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         spi_clk, mosi, cs, miso;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_load, tx_ready, rx_valid, frame_err;

  spi_slave_rx #(.DATA_WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .reset(reset_n), .spi_clk(spi_clk), .mosi(mosi), .cs(cs),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cyc = 0;
  int pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  typedef struct {
    logic         pre;
    logic [W-1:0] txw;
    logic [15:0]  bits;
    int           n;
    int           mid;
    logic [W-1:0] exp_rx;
    int           exp_v;
    int           exp_e;
    logic [W-1:0] exp_miso;
  } vec_t;

  vec_t tbl[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_latency(input string name, input int lat);
    total_cnt++;
    if (lat >= 3 && lat <= 4) pass_cnt++;
    else $display("FAIL %s: rx_valid latency %0d clk, expected 3..4", name, lat);
  endtask

  // Master side: clocks n bits (MSB of bits[n-1:0] first) and samples miso on each rise.
  task automatic send_clocks(input logic [15:0] bits, input int n, input int mid,
                             output logic [W-1:0] cap, output int r6);
    cap = '0;
    r6  = 0;
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      tick(HALF);
      spi_clk = 1'b1;
      if (i < W) cap[W-1-i] = miso;
      if (i == W-1) r6 = cyc;
      if (i == mid) begin
        tx_data = 6'h3F;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(HALF-1);
      end else begin
        tick(HALF);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input logic pre, input logic [W-1:0] txw,
                           input logic [15:0] bits, input int n, input int mid,
                           input logic [W-1:0] exp_rx, input int exp_v, input int exp_e,
                           input logic [W-1:0] exp_miso);
    int           v0, e0, r6;
    logic [W-1:0] cap, mask;
    if (pre) begin
      tx_data = txw;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
    end
    v0 = valid_cnt;
    e0 = err_cnt;
    cs = 1'b0;
    tick(HALF);
    send_clocks(bits, n, mid, cap, r6);
    tick(HALF);
    cs = 1'b1;
    tick(8);
    mask = '0;
    for (int i = 0; i < W && i < n; i++) mask[W-1-i] = 1'b1;
    chk({name, ".rx_data"}, int'(rx_data), int'(exp_rx));
    chk({name, ".rx_valid_pulses"}, valid_cnt - v0, exp_v);
    chk({name, ".frame_err_pulses"}, err_cnt - e0, exp_e);
    chk({name, ".miso_bits"}, int'(cap & mask), int'(exp_miso & mask));
    chk({name, ".miso_idle"}, int'(miso), 0);
    chk({name, ".tx_ready"}, int'(tx_ready), 1);
    if (exp_v == 1 && n >= W) chk_latency({name, ".latency"}, valid_cyc - r6);
    $display("frame %s: n=%0d sent=0x%0h rx_data=0x%0h miso=0x%0h", name, n, bits, rx_data, cap & mask);
  endtask

  initial begin
    logic [W-1:0] model_rx, reply, w, emiso, cap;
    logic [15:0]  bits;
    logic         pre;
    int           n, kind, ev, ee, v0, e0, r6;

    tbl[0] = '{1'b1, 6'h2D, 16'h002D, 6, -1, 6'h2D, 1, 0, 6'h2D};
    tbl[1] = '{1'b0, 6'h00, 16'h0005, 3, -1, 6'h2D, 0, 1, 6'h00};
    tbl[2] = '{1'b0, 6'h00, 16'h0015, 6, -1, 6'h15, 1, 0, 6'h00};
    tbl[3] = '{1'b1, 6'h33, 16'h0000, 6, -1, 6'h00, 1, 0, 6'h33};
    tbl[4] = '{1'b0, 6'h00, 16'h00FC, 8, -1, 6'h3F, 1, 0, 6'h00};
    tbl[5] = '{1'b0, 6'h00, 16'h002A, 6,  2, 6'h2A, 1, 0, 6'h00};
    tbl[6] = '{1'b0, 6'h00, 16'h0011, 6, -1, 6'h11, 1, 0, 6'h00};
    tbl[7] = '{1'b1, 6'h3F, 16'h003F, 6, -1, 6'h3F, 1, 0, 6'h3F};
    tbl[8] = '{1'b1, 6'h15, 16'h0000, 0, -1, 6'h3F, 0, 0, 6'h00};
    tbl[9] = '{1'b1, 6'h2A, 16'h0013, 5, -1, 6'h3F, 0, 1, 6'h2A};

    reset_n = 1'b0; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = '0;
    tick(3);
    chk("reset.miso", int'(miso), 0);
    chk("reset.tx_ready", int'(tx_ready), 0);
    chk("reset.rx_data", int'(rx_data), 0);
    chk("reset.rx_valid", int'(rx_valid), 0);
    chk("reset.frame_err", int'(frame_err), 0);
    reset_n = 1'b1;
    tick(10);
    chk("startup.tx_ready", int'(tx_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].pre, tbl[i].txw, tbl[i].bits, tbl[i].n,
                tbl[i].mid, tbl[i].exp_rx, tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_miso);
    end
    model_rx = 6'h3F;

    // Random frames: reply is the preloaded word (or zero), rx_data is the first W bits
    // of any frame with at least W clocks, and a short non-empty frame is an error.
    for (int k = 0; k < 30; k++) begin
      pre  = 1'($urandom_range(0, 1));
      w    = W'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       n = 0;
        1:       n = $urandom_range(1, W-1);
        2:       n = W;
        default: n = W + $urandom_range(1, 3);
      endcase
      if (n >= W) bits = (16'(w) << (n - W)) | (16'($urandom) & ((16'd1 << (n - W)) - 16'd1));
      else        bits = 16'(w) >> (W - n);
      reply = W'($urandom);
      emiso = pre ? reply : '0;
      if (n >= W) model_rx = w;
      ev = (n >= W) ? 1 : 0;
      ee = (n >= 1 && n < W) ? 1 : 0;
      run_frame($sformatf("rnd%0d", k), pre, reply, bits, n, -1, model_rx, ev, ee, emiso);
    end

    // Reset three bits into a frame with cs held low throughout.
    v0 = valid_cnt;
    e0 = err_cnt;
    cs = 1'b0;
    tick(HALF);
    send_clocks(16'h0005, 3, -1, cap, r6);
    reset_n = 1'b0;
    tick(2);
    chk("midreset.miso", int'(miso), 0);
    chk("midreset.tx_ready", int'(tx_ready), 0);
    chk("midreset.rx_data", int'(rx_data), 0);
    chk("midreset.rx_valid", int'(rx_valid), 0);
    chk("midreset.frame_err", int'(frame_err), 0);
    reset_n = 1'b1;
    tick(10);
    send_clocks(16'h003F, 6, -1, cap, r6);
    tick(8);
    chk("midreset.no_frame_tx_ready", int'(tx_ready), 0);
    chk("midreset.no_valid", valid_cnt - v0, 0);
    chk("midreset.no_err", err_cnt - e0, 0);
    chk("midreset.rx_data_held", int'(rx_data), 0);
    $display("reset sequence: rx_data=0x%0h tx_ready=%0b", rx_data, tx_ready);
    cs = 1'b1;
    tick(8);
    chk("midreset.idle_tx_ready", int'(tx_ready), 1);
    run_frame("post_reset", 1'b0, 6'h00, 16'h002A, 6, -1, 6'h2A, 1, 0, 6'h00);

    chk("strobe_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
